// File: rtl/approx_bist_pkg.sv
// Shared definitions for the approximate-adder self-test controller.
// Holds the sweep FSM state type and the width helpers that size the
// statistic accumulators so that a full exhaustive sweep cannot overflow.
package approx_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

    // Pair counters: 2^(2W) pairs need 2W+1 bits to hold the final count.
    function automatic int cnt_w(input int w);
        return 2 * w + 1;
    endfunction

    // Signed error sum: |e| < 2^(W+1) over 2^(2W) pairs, plus a sign bit.
    function automatic int err_sum_w(input int w);
        return 3 * w + 2;
    endfunction

    // Absolute error sum: same magnitude bound, unsigned.
    function automatic int abs_sum_w(input int w);
        return 3 * w + 1;
    endfunction

    // Squared error sum: e^2 < 2^(2W+2) over 2^(2W) pairs.
    function automatic int sq_sum_w(input int w);
        return 4 * w + 2;
    endfunction

endpackage

// File: rtl/bist_delay_line.sv
// Fixed-depth delay line that keeps the exact sum and its valid flag aligned
// with the pipeline of the adder-under-test.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, clears every stage (and so every valid)
//   din   : {valid, exact_sum} entering the line
//   dout  : the same word DEPTH cycles later (DEPTH=0 passes straight through)
module bist_delay_line #(
    parameter int DEPTH = 1,
    parameter int DW    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_pipe
            logic [DW-1:0] stage_r [DEPTH];

            // Shift register; stage 0 takes the new word each cycle.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_r[i] <= {DW{1'b0}};
                    end
                end else begin
                    stage_r[0] <= din;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign dout = stage_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/approx_adder_bist.sv
// Built-in self-test controller for approximate adders. Sweeps every operand
// pair (b inner, a outer) into an external adder-under-test, compares its sum
// against the exact sum and accumulates error statistics on-chip.
//   clk, rst_n         : clock and synchronous active-low reset
//   start              : one-cycle pulse, accepted in IDLE or DONE
//   dut_a, dut_b       : registered operands to the adder-under-test
//   dut_sum            : approximate sum returned DUT_LAT cycles later
//   busy, done         : sweep in progress / results valid and final
//   total_cases        : number of pairs checked
//   err_count          : pairs with nonzero error
//   err_sum            : signed sum of (approx - exact)
//   abs_err_sum        : sum of |approx - exact|
//   sq_err_sum         : sum of (approx - exact)^2
//   max_abs_err        : largest |approx - exact|
module approx_adder_bist
    import approx_bist_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DUT_LAT = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic [WIDTH-1:0]              dut_a,
    output logic [WIDTH-1:0]              dut_b,
    input  logic [WIDTH:0]                dut_sum,
    output logic                          busy,
    output logic                          done,
    output logic [cnt_w(WIDTH)-1:0]       total_cases,
    output logic [cnt_w(WIDTH)-1:0]       err_count,
    output logic [err_sum_w(WIDTH)-1:0]   err_sum,
    output logic [abs_sum_w(WIDTH)-1:0]   abs_err_sum,
    output logic [sq_sum_w(WIDTH)-1:0]    sq_err_sum,
    output logic [WIDTH:0]                max_abs_err
);

    localparam int CNT_W   = cnt_w(WIDTH);
    localparam int ESUM_W  = err_sum_w(WIDTH);
    localparam int ASUM_W  = abs_sum_w(WIDTH);
    localparam int SQ_W    = sq_sum_w(WIDTH);
    localparam int PAIR_W  = 2 * WIDTH;
    localparam int E_W     = WIDTH + 2;
    localparam int DRAIN_W = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;

    bist_state_e            state_r;
    bist_state_e            state_s;
    logic [PAIR_W-1:0]      pair_r;
    logic [DRAIN_W-1:0]     drain_cnt_r;
    logic                   accept_s;
    logic                   last_pair_s;
    logic                   drain_end_s;

    logic [WIDTH:0]         exact_s;
    logic                   run_vld_s;
    logic [WIDTH:0]         exact_dl_s;
    logic                   vld_dl_s;

    logic signed [E_W-1:0]  err_s;
    logic signed [E_W-1:0]  err_r;
    logic                   err_vld_r;
    logic [WIDTH:0]         abs_s;
    logic [2*WIDTH+1:0]     sq_s;

    logic                   busy_r;
    logic                   done_r;
    logic [CNT_W-1:0]       total_r;
    logic [CNT_W-1:0]       err_cnt_r;
    logic [ESUM_W-1:0]      err_sum_r;
    logic [ASUM_W-1:0]      abs_sum_r;
    logic [SQ_W-1:0]        sq_sum_r;
    logic [WIDTH:0]         max_abs_r;

    // Sweep position is a single 2W-bit counter: high half is a, low half b.
    assign dut_a       = pair_r[PAIR_W-1:WIDTH];
    assign dut_b       = pair_r[WIDTH-1:0];
    assign last_pair_s = (pair_r == {PAIR_W{1'b1}});
    assign drain_end_s = (drain_cnt_r == DRAIN_W'(DUT_LAT - 1));

    // Start is honoured only while no sweep is in flight.
    always_comb begin
        accept_s = 1'b0;
        if (start && ((state_r == ST_IDLE) || (state_r == ST_DONE))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Next-state logic for the sweep FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RUN: begin
                if (last_pair_s) begin
                    state_s = (DUT_LAT > 0) ? ST_DRAIN : ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_end_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand counter and drain counter; operands hold after the last pair.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pair_r      <= {PAIR_W{1'b0}};
            drain_cnt_r <= {DRAIN_W{1'b0}};
        end else if (accept_s) begin
            pair_r      <= {PAIR_W{1'b0}};
            drain_cnt_r <= {DRAIN_W{1'b0}};
        end else if ((state_r == ST_RUN) && !last_pair_s) begin
            pair_r <= pair_r + PAIR_W'(1);
        end else if (state_r == ST_DRAIN) begin
            drain_cnt_r <= drain_cnt_r + DRAIN_W'(1);
        end
    end

    // Exact reference travels alongside the adder-under-test's pipeline.
    assign exact_s   = {1'b0, dut_a} + {1'b0, dut_b};
    assign run_vld_s = (state_r == ST_RUN);

    generate
        if (DUT_LAT > 0) begin : g_dly
            bist_delay_line #(
                .DEPTH (DUT_LAT),
                .DW    (WIDTH + 2)
            ) u_dly (
                .clk   (clk),
                .rst_n (rst_n),
                .din   ({run_vld_s, exact_s}),
                .dout  ({vld_dl_s, exact_dl_s})
            );
        end else begin : g_nodly
            assign vld_dl_s   = run_vld_s;
            assign exact_dl_s = exact_s;
        end
    endgenerate

    assign err_s = $signed({1'b0, dut_sum}) - $signed({1'b0, exact_dl_s});

    // Error sample stage: dut_sum is captured at the edge ending its cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_vld_r <= 1'b0;
            err_r     <= {E_W{1'b0}};
        end else if (accept_s) begin
            err_vld_r <= 1'b0;
            err_r     <= {E_W{1'b0}};
        end else begin
            err_vld_r <= vld_dl_s;
            err_r     <= err_s;
        end
    end

    // |e| always fits in WIDTH+1 bits, so negate only the low bits.
    assign abs_s = err_r[E_W-1] ? (~err_r[WIDTH:0] + (WIDTH+1)'(1)) : err_r[WIDTH:0];
    assign sq_s  = {{(WIDTH+1){1'b0}}, abs_s} * {{(WIDTH+1){1'b0}}, abs_s};

    // Statistic accumulators, cleared on reset and on each accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n || accept_s) begin
            total_r   <= {CNT_W{1'b0}};
            err_cnt_r <= {CNT_W{1'b0}};
            err_sum_r <= {ESUM_W{1'b0}};
            abs_sum_r <= {ASUM_W{1'b0}};
            sq_sum_r  <= {SQ_W{1'b0}};
            max_abs_r <= {(WIDTH+1){1'b0}};
        end else if (err_vld_r) begin
            total_r   <= total_r + CNT_W'(1);
            if (err_r != {E_W{1'b0}}) begin
                err_cnt_r <= err_cnt_r + CNT_W'(1);
            end
            err_sum_r <= err_sum_r + {{(ESUM_W-E_W){err_r[E_W-1]}}, err_r};
            abs_sum_r <= abs_sum_r + ASUM_W'(abs_s);
            sq_sum_r  <= sq_sum_r + SQ_W'(sq_s);
            if (abs_s > max_abs_r) begin
                max_abs_r <= abs_s;
            end
        end
    end

    // Status flags trail the FSM by one edge so done rises with the last
    // accumulation, not with the last sample.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= accept_s || (state_r == ST_RUN) || (state_r == ST_DRAIN);
            done_r <= (state_r == ST_DONE) && !accept_s;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign total_cases = total_r;
    assign err_count   = err_cnt_r;
    assign err_sum     = err_sum_r;
    assign abs_err_sum = abs_sum_r;
    assign sq_err_sum  = sq_sum_r;
    assign max_abs_err = max_abs_r;

endmodule

// File: tb/tb_approx_adder_bist.sv
// Directed bench for approx_adder_bist. Three WIDTH=8 controllers sweep in
// parallel (exact adder, LSB-forced adder, two-stage registered adder); a
// WIDTH=2 controller against a constant-zero adder exercises back-to-back
// starts, ignored mid-sweep starts and mid-sweep reset.
module tb_approx_adder_bist;
    import approx_bist_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, start_a, rst_b, start_b;

    // WIDTH=8, DUT_LAT=0, exact adder
    logic [7:0]  e0_a, e0_b;
    logic [8:0]  e0_sum, e0_mx;
    logic        e0_busy, e0_done;
    logic [16:0] e0_tot, e0_cnt;
    logic [25:0] e0_es;
    logic [24:0] e0_as;
    logic [33:0] e0_sq;

    // WIDTH=8, DUT_LAT=0, sum LSB forced to 0
    logic [7:0]  l0_a, l0_b;
    logic [8:0]  l0_sum, l0_mx;
    logic        l0_busy, l0_done;
    logic [16:0] l0_tot, l0_cnt;
    logic [25:0] l0_es;
    logic [24:0] l0_as;
    logic [33:0] l0_sq;

    // WIDTH=8, DUT_LAT=2, registered two-stage exact adder
    logic [7:0]  e2_a, e2_b;
    logic [8:0]  e2_sum, e2_mx, e2_s1, e2_s2;
    logic        e2_busy, e2_done;
    logic [16:0] e2_tot, e2_cnt;
    logic [25:0] e2_es;
    logic [24:0] e2_as;
    logic [33:0] e2_sq;

    // WIDTH=2, DUT_LAT=0, constant-zero adder
    logic [1:0]  z_a, z_b;
    logic [2:0]  z_sum, z_mx;
    logic        z_busy, z_done;
    logic [4:0]  z_tot, z_cnt;
    logic [7:0]  z_es;
    logic [6:0]  z_as;
    logic [9:0]  z_sq;

    assign e0_sum = {1'b0, e0_a} + {1'b0, e0_b};
    assign l0_sum = ({1'b0, l0_a} + {1'b0, l0_b}) & 9'h1FE;
    assign z_sum  = 3'd0;
    always_ff @(posedge clk) begin
        e2_s1 <= {1'b0, e2_a} + {1'b0, e2_b};
        e2_s2 <= e2_s1;
    end
    assign e2_sum = e2_s2;

    approx_adder_bist #(.WIDTH(8), .DUT_LAT(0)) u_e0 (
        .clk(clk), .rst_n(rst_a), .start(start_a), .dut_a(e0_a), .dut_b(e0_b),
        .dut_sum(e0_sum), .busy(e0_busy), .done(e0_done), .total_cases(e0_tot),
        .err_count(e0_cnt), .err_sum(e0_es), .abs_err_sum(e0_as),
        .sq_err_sum(e0_sq), .max_abs_err(e0_mx));

    approx_adder_bist #(.WIDTH(8), .DUT_LAT(0)) u_l0 (
        .clk(clk), .rst_n(rst_a), .start(start_a), .dut_a(l0_a), .dut_b(l0_b),
        .dut_sum(l0_sum), .busy(l0_busy), .done(l0_done), .total_cases(l0_tot),
        .err_count(l0_cnt), .err_sum(l0_es), .abs_err_sum(l0_as),
        .sq_err_sum(l0_sq), .max_abs_err(l0_mx));

    approx_adder_bist #(.WIDTH(8), .DUT_LAT(2)) u_e2 (
        .clk(clk), .rst_n(rst_a), .start(start_a), .dut_a(e2_a), .dut_b(e2_b),
        .dut_sum(e2_sum), .busy(e2_busy), .done(e2_done), .total_cases(e2_tot),
        .err_count(e2_cnt), .err_sum(e2_es), .abs_err_sum(e2_as),
        .sq_err_sum(e2_sq), .max_abs_err(e2_mx));

    approx_adder_bist #(.WIDTH(2), .DUT_LAT(0)) u_z (
        .clk(clk), .rst_n(rst_b), .start(start_b), .dut_a(z_a), .dut_b(z_b),
        .dut_sum(z_sum), .busy(z_busy), .done(z_done), .total_cases(z_tot),
        .err_count(z_cnt), .err_sum(z_es), .abs_err_sum(z_as),
        .sq_err_sum(z_sq), .max_abs_err(z_mx));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full WIDTH=2 zero-adder result set.
    task automatic chk_z_results(input string tag);
        chk({tag, "_busy"}, 64'(z_busy), 64'sd0);
        chk({tag, "_tot"},  64'(z_tot), 64'sd16);
        chk({tag, "_cnt"},  64'(z_cnt), 64'sd15);
        chk({tag, "_es"},   64'($signed(z_es)), -64'sd48);
        chk({tag, "_as"},   64'(z_as), 64'sd48);
        chk({tag, "_sq"},   64'(z_sq), 64'sd184);
        chk({tag, "_mx"},   64'(z_mx), 64'sd6);
    endtask

    int edges;
    int e0_edges, l0_edges, e2_edges, drain_cycles;
    bit e0_seen, l0_seen, e2_seen;

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
        repeat (2) tick();

        // Reset state
        chk("rst_e0_busy", 64'(e0_busy), 64'sd0);
        chk("rst_e0_done", 64'(e0_done), 64'sd0);
        chk("rst_e0_a",    64'(e0_a), 64'sd0);
        chk("rst_e0_tot",  64'(e0_tot), 64'sd0);
        chk("rst_e2_sq",   64'(e2_sq), 64'sd0);
        chk("rst_z_done",  64'(z_done), 64'sd0);
        chk("rst_z_mx",    64'(z_mx), 64'sd0);

        // WIDTH=2 sweep against constant-zero adder
        rst_b = 1'b1; tick();
        start_b = 1'b1; tick(); start_b = 1'b0;
        chk("z1_busy_up", 64'(z_busy), 64'sd1);
        chk("z1_done_lo", 64'(z_done), 64'sd0);
        edges = 0;
        while (z_done !== 1'b1 && edges < 64) begin tick(); edges++; end
        chk("z1_latency", 64'(edges), 64'sd17);
        chk_z_results("z1");

        // Back-to-back: start in the first done cycle, with a start mid-RUN
        start_b = 1'b1; tick(); start_b = 1'b0;
        chk("z2_done_drop", 64'(z_done), 64'sd0);
        chk("z2_busy_up",   64'(z_busy), 64'sd1);
        chk("z2_tot_clr",   64'(z_tot), 64'sd0);
        chk("z2_mx_clr",    64'(z_mx), 64'sd0);
        repeat (5) tick();
        chk("z2_pair5_a", 64'(z_a), 64'sd1);
        chk("z2_pair5_b", 64'(z_b), 64'sd1);
        start_b = 1'b1; tick(); start_b = 1'b0;
        edges = 6;
        while (z_done !== 1'b1 && edges < 64) begin tick(); edges++; end
        chk("z2_latency", 64'(edges), 64'sd17);
        chk_z_results("z2");

        // Reset held for one edge mid-RUN
        start_b = 1'b1; tick(); start_b = 1'b0;
        repeat (6) tick();
        rst_b = 1'b0; tick(); rst_b = 1'b1;
        chk("zr_busy",  64'(z_busy), 64'sd0);
        chk("zr_done",  64'(z_done), 64'sd0);
        chk("zr_a",     64'(z_a), 64'sd0);
        chk("zr_b",     64'(z_b), 64'sd0);
        chk("zr_tot",   64'(z_tot), 64'sd0);
        chk("zr_es",    64'(z_es), 64'sd0);
        chk("zr_sq",    64'(z_sq), 64'sd0);
        chk("zr_idle",  64'(u_z.state_r == ST_IDLE), 64'sd1);
        tick();
        chk("zr_stay",  64'(z_tot), 64'sd0);

        // Clean sweep after the abort
        start_b = 1'b1; tick(); start_b = 1'b0;
        edges = 0;
        while (z_done !== 1'b1 && edges < 64) begin tick(); edges++; end
        chk("z3_latency", 64'(edges), 64'sd17);
        chk_z_results("z3");

        // Parallel WIDTH=8 sweeps
        rst_a = 1'b1; tick();
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("a_busy_up", 64'(e2_busy), 64'sd1);
        edges = 0; drain_cycles = 0;
        e0_seen = 1'b0; l0_seen = 1'b0; e2_seen = 1'b0;
        e0_edges = 0; l0_edges = 0; e2_edges = 0;
        while (!(e0_seen && l0_seen && e2_seen) && edges < 70000) begin
            tick(); edges++;
            if (edges == 300) begin
                chk("e0_pair300_a", 64'(e0_a), 64'sd1);
                chk("e0_pair300_b", 64'(e0_b), 64'sd44);
            end
            if (u_e2.state_r == ST_DRAIN) begin
                drain_cycles++;
                chk("e2_drain_hold_a", 64'(e2_a), 64'sd255);
            end
            if (!e0_seen && e0_done) begin e0_seen = 1'b1; e0_edges = edges; end
            if (!l0_seen && l0_done) begin l0_seen = 1'b1; l0_edges = edges; end
            if (!e2_seen && e2_done) begin e2_seen = 1'b1; e2_edges = edges; end
        end
        chk("e0_latency", 64'(e0_edges), 64'sd65537);
        chk("l0_latency", 64'(l0_edges), 64'sd65537);
        chk("e2_latency", 64'(e2_edges), 64'sd65539);
        chk("e2_drain",   64'(drain_cycles), 64'sd2);

        chk("e0_tot", 64'(e0_tot), 64'sd65536);
        chk("e0_cnt", 64'(e0_cnt), 64'sd0);
        chk("e0_es",  64'($signed(e0_es)), 64'sd0);
        chk("e0_as",  64'(e0_as), 64'sd0);
        chk("e0_sq",  64'(e0_sq), 64'sd0);
        chk("e0_mx",  64'(e0_mx), 64'sd0);

        chk("l0_tot", 64'(l0_tot), 64'sd65536);
        chk("l0_cnt", 64'(l0_cnt), 64'sd32768);
        chk("l0_es",  64'($signed(l0_es)), -64'sd32768);
        chk("l0_as",  64'(l0_as), 64'sd32768);
        chk("l0_sq",  64'(l0_sq), 64'sd32768);
        chk("l0_mx",  64'(l0_mx), 64'sd1);

        chk("e2_tot", 64'(e2_tot), 64'sd65536);
        chk("e2_cnt", 64'(e2_cnt), 64'sd0);
        chk("e2_es",  64'($signed(e2_es)), 64'sd0);
        chk("e2_sq",  64'(e2_sq), 64'sd0);
        chk("e2_mx",  64'(e2_mx), 64'sd0);
        chk("e2_busy_dn", 64'(e2_busy), 64'sd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
